// File: rtl/tis_pkg.sv
// Shared TIS-100 word type, value range and port/operand codes.
package tis_pkg;

  typedef logic signed [10:0] tis_word_t;

  localparam int TIS_MAX = 999;
  localparam int TIS_MIN = -999;

  typedef enum int {
    NIL   = 1000,
    ACC   = 1001,
    ANY   = 1002,
    LAST  = 1003,
    LEFT  = 1004,
    RIGHT = 1005,
    UP    = 1006,
    DOWN  = 1007
  } tis_port_e;

  function automatic logic tisInRange(input int v);
    return (v <= TIS_MAX) && (v >= TIS_MIN);
  endfunction

endpackage

// File: rtl/port_link_lane.sv
// One direction of a port_link: storage, wdone pulse, error detect.
// PORT_LINK_SKID_EN selects a 2-entry FIFO instead of a single slot.
module link_lane
  import tis_pkg::*;
#(
  parameter int W = 11
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic signed [W-1:0] wdata,
  input  logic                write,
  output logic                wready,
  output logic                wdone,
  output logic signed [W-1:0] rdata,
  output logic                rready,
  input  logic                read,
  output logic                err
);

  logic doWrite;
  logic doRead;
  logic badWrite;
  logic badRange;
  logic badRead;

  assign badWrite = write & ~doWrite;
  assign badRead  = read & ~rready;
  assign badRange = doWrite & ~tisInRange(int'(wdata));

`ifdef PORT_LINK_SKID_EN

  logic signed [W-1:0] mem [2];
  logic [1:0] count;
  logic rdPtr;
  logic wrPtr;

  assign wready  = (count != 2'd2);
  assign rready  = (count != 2'd0);
  assign rdata   = mem[rdPtr];
  assign doRead  = read & rready;
  // A full FIFO still takes a write when the head leaves this cycle.
  assign doWrite = write & (wready | doRead);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      count  <= 2'd0;
      rdPtr  <= 1'b0;
      wrPtr  <= 1'b0;
      wdone  <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (doWrite) begin
        mem[wrPtr] <= wdata;
        wrPtr      <= ~wrPtr;
      end
      if (doRead) rdPtr <= ~rdPtr;
      unique case ({doWrite, doRead})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      wdone <= doRead;
      if (badWrite | badRead | badRange) err <= 1'b1;
    end
  end

`else

  logic full;
  logic signed [W-1:0] dataQ;

  assign wready  = ~full;
  assign rready  = full;
  assign rdata   = dataQ;
  assign doWrite = write & ~full;
  assign doRead  = read & full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full  <= 1'b0;
      dataQ <= '0;
      wdone <= 1'b0;
      err   <= 1'b0;
    end else begin
      if (doWrite) begin
        dataQ <= wdata;
        full  <= 1'b1;
      end else if (doRead) begin
        full <= 1'b0;
      end
      wdone <= doRead;
      if (badWrite | badRead | badRange) err <= 1'b1;
    end
  end

`endif

endmodule

// File: rtl/port_link.sv
// Bidirectional blocking channel between two neighbouring cores.
// Optional PORT_LINK_SKID_EN gives each lane a 2-entry FIFO.
module port_link
  import tis_pkg::*;
#(
  parameter int W = 11
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic signed [W-1:0] a_data,
  input  logic                a_write,
  output logic                a_wready,
  output logic                a_wdone,
  output logic signed [W-1:0] a_rdata,
  output logic                a_rready,
  input  logic                a_read,
  input  logic signed [W-1:0] b_data,
  input  logic                b_write,
  output logic                b_wready,
  output logic                b_wdone,
  output logic signed [W-1:0] b_rdata,
  output logic                b_rready,
  input  logic                b_read,
  output logic                err
);

  logic errAb;
  logic errBa;

  link_lane #(.W(W)) laneAb (
    .clk    (clk),
    .rst_n  (rst_n),
    .wdata  (a_data),
    .write  (a_write),
    .wready (a_wready),
    .wdone  (a_wdone),
    .rdata  (b_rdata),
    .rready (b_rready),
    .read   (b_read),
    .err    (errAb)
  );

  link_lane #(.W(W)) laneBa (
    .clk    (clk),
    .rst_n  (rst_n),
    .wdata  (b_data),
    .write  (b_write),
    .wready (b_wready),
    .wdone  (b_wdone),
    .rdata  (a_rdata),
    .rready (a_rready),
    .read   (a_read),
    .err    (errBa)
  );

  assign err = errAb | errBa;

endmodule

// File: tb/tb_port_link.sv
// Directed self-checking bench for port_link.
// Covers the skid FIFO when PORT_LINK_SKID_EN is defined.
module tb_port_link;

  logic clk = 1'b0;
  logic rst_n;
  logic signed [10:0] a_data, b_data;
  logic a_write, a_read, b_write, b_read;
  logic a_wready, a_wdone, a_rready;
  logic b_wready, b_wdone, b_rready;
  logic signed [10:0] a_rdata, b_rdata;
  logic err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  port_link #(.W(11)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_data   (a_data),
    .a_write  (a_write),
    .a_wready (a_wready),
    .a_wdone  (a_wdone),
    .a_rdata  (a_rdata),
    .a_rready (a_rready),
    .a_read   (a_read),
    .b_data   (b_data),
    .b_write  (b_write),
    .b_wready (b_wready),
    .b_wdone  (b_wdone),
    .b_rdata  (b_rdata),
    .b_rready (b_rready),
    .b_read   (b_read),
    .err      (err)
  );

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_write = 0; a_read = 0;
    b_write = 0; b_read = 0;
  endtask

  task automatic doReset();
    idle();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    tick();
  endtask

  initial begin
    a_data = 0; b_data = 0;
    idle();
    rst_n = 0;
    tick();
    tick();
    // reset values
    chk("rst a_wready", a_wready, 1);
    chk("rst b_wready", b_wready, 1);
    chk("rst a_rready", a_rready, 0);
    chk("rst b_rready", b_rready, 0);
    chk("rst a_wdone", a_wdone, 0);
    chk("rst b_wdone", b_wdone, 0);
    chk("rst a_rdata", a_rdata, 0);
    chk("rst b_rdata", b_rdata, 0);
    chk("rst err", err, 0);
    rst_n = 1;
    tick();

    // A writes 123, B reads next cycle
    a_data = 123; a_write = 1;
    tick();
    a_write = 0;
    chk("t1 b_rready", b_rready, 1);
    chk("t1 b_rdata", b_rdata, 123);
    chk("t1 a_wdone early", a_wdone, 0);
`ifndef PORT_LINK_SKID_EN
    chk("t1 a_wready", a_wready, 0);
`endif
    b_read = 1;
    tick();
    b_read = 0;
    chk("t1 a_wdone", a_wdone, 1);
    chk("t1 a_wready after", a_wready, 1);
    chk("t1 b_rready after", b_rready, 0);
    // new write immediately in M+1
    a_data = 55; a_write = 1;
    tick();
    a_write = 0;
    chk("t1 wdone width", a_wdone, 0);
    chk("t1 b_rdata 55", b_rdata, 55);
    chk("t1 b_rready 55", b_rready, 1);
    chk("t1 err", err, 0);
    b_read = 1;
    tick();
    b_read = 0;
    chk("t1 a_wdone 55", a_wdone, 1);
    tick();

`ifndef PORT_LINK_SKID_EN
    // write while FULL is dropped and flagged
    a_data = 7; a_write = 1;
    tick();
    a_data = 5;
    tick();
    a_write = 0;
    chk("t2 b_rdata kept", b_rdata, 7);
    chk("t2 err", err, 1);
    chk("t2 b_rready", b_rready, 1);
    tick();
    chk("t2 err sticky", err, 1);
    b_read = 1;
    tick();
    b_read = 0;
    chk("t2 a_wdone", a_wdone, 1);
    chk("t2 err sticky2", err, 1);
    doReset();
    chk("t2 err cleared", err, 0);
`endif

    // both directions in the same cycle at the range limits
    a_data = -999; a_write = 1;
    b_data = 999;  b_write = 1;
    tick();
    idle();
    chk("t3 b_rdata", b_rdata, -999);
    chk("t3 a_rdata", a_rdata, 999);
    chk("t3 a_rready", a_rready, 1);
    chk("t3 err", err, 0);
    a_read = 1; b_read = 1;
    tick();
    idle();
    chk("t3 a_wdone", a_wdone, 1);
    chk("t3 b_wdone", b_wdone, 1);
    chk("t3 a_rready after", a_rready, 0);
    tick();

    // reset while A->B holds a word
    a_data = 42; a_write = 1;
    tick();
    a_write = 0;
    chk("t4 b_rready pre", b_rready, 1);
    rst_n = 0;
    #1;
    chk("t4 b_rready async", b_rready, 0);
    chk("t4 a_wready async", a_wready, 1);
    tick();
    rst_n = 1;
    tick();
    chk("t4 no wdone", a_wdone, 0);
    tick();
    chk("t4 no wdone2", a_wdone, 0);
    chk("t4 b_rready post", b_rready, 0);

    // out-of-range write is stored and flagged
    a_data = 1000; a_write = 1;
    tick();
    a_write = 0;
    chk("t5 b_rdata", b_rdata, 1000);
    chk("t5 err", err, 1);
    doReset();

    // read on an empty lane
    a_read = 1;
    tick();
    a_read = 0;
    chk("t6 err", err, 1);
    chk("t6 a_rready", a_rready, 0);
    chk("t6 b_wdone", b_wdone, 0);
    doReset();

`ifdef PORT_LINK_SKID_EN
    // two-deep skid with simultaneous push/pop while full
    a_data = 1; a_write = 1;
    tick();
    chk("sk a_wready 1", a_wready, 1);
    a_data = 2;
    tick();
    a_write = 0;
    chk("sk a_wready full", a_wready, 0);
    chk("sk head 1", b_rdata, 1);
    a_data = 3; a_write = 1; b_read = 1;
    tick();
    a_write = 0;
    chk("sk wdone 1", a_wdone, 1);
    chk("sk still full", a_wready, 0);
    chk("sk head 2", b_rdata, 2);
    chk("sk err", err, 0);
    tick();
    chk("sk wdone 2", a_wdone, 1);
    chk("sk head 3", b_rdata, 3);
    chk("sk a_wready", a_wready, 1);
    tick();
    b_read = 0;
    chk("sk wdone 3", a_wdone, 1);
    chk("sk empty", b_rready, 0);
    tick();
    chk("sk wdone end", a_wdone, 0);
    chk("sk err end", err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/port_link.md
# port_link

Point-to-point channel between two adjacent `core` nodes; the responder end of the core's port handshake. Each core drives `out`, a `writeX` pulse and a `readX` pulse, and consumes `wreadyX`, `rreadyX` and the incoming data word. `port_link` carries one word A→B and one word B→A, with TIS-100 blocking semantics: a value sits in the link until the far side reads it, then the writer gets a completion pulse. The mesh instantiates one link per horizontal and vertical neighbour pair.

## Interface
- `W`, default 11: data width; signed, legal range −999..999.
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `a_data`  in  W  word from node A (its `out`).
- `a_write`  in  1  A write strobe, one cycle per word.
- `a_wready`  out  1  A→B lane can accept a write.
- `a_wdone`  out  1  one-cycle pulse: B consumed a word A wrote.
- `a_rdata`  out  W  B→A word presented to A.
- `a_rready`  out  1  `a_rdata` valid.
- `a_read`  in  1  A read strobe.
- `b_data`, `b_write`, `b_wready`, `b_wdone`, `b_rdata`, `b_rready`, `b_read`: mirror of the A ports for node B.
- `err`  out  1  sticky protocol-violation flag.

## Operation
- Two independent lanes, A→B and B→A, with identical logic; the A→B lane is described here.
- Lane states:
  - EMPTY: `a_wready=1`, `b_rready=0`.
  - FULL: `a_wready=0`, `b_rready=1`, `b_rdata` = stored word.
- Accepted write (`a_write & a_wready`): capture `a_data`, go EMPTY→FULL.
- Accepted read (`b_read & b_rready`): go FULL→EMPTY and pulse `a_wdone` on the next cycle.
- Write while `a_wready=0`: ignored; data is not overwritten; sets `err`.
- Read while `b_rready=0`: ignored; sets `err`.
- Out-of-range data (>999 or <−999): stored unchanged; sets `err`.
- `err` clears only on reset.
- `b_rdata` holds its last value when the lane is EMPTY; the reader must not use it without `rready`.
- Each lane's state is fully independent of the other lane.

## Timing
- Reset values:
  - `a_wready = b_wready = 1`.
  - `a_rready = b_rready = 0`.
  - `a_wdone = b_wdone = 0`.
  - `a_rdata = b_rdata = 0`.
  - `err = 0`.
- All outputs are registered; no combinational path from any input to any output.
- Write accepted in cycle N → `b_rready=1` and `a_wready=0` from N+1. Earliest read is at N+1.
- Read accepted in cycle M → `b_rready=0`, `a_wready=1` and `a_wdone=1` in M+1. `a_wdone` is exactly one cycle wide. A new write is accepted at M+1.
- Minimum round trip per word without skid: 2 cycles.
- Reset mid-transfer: the stored word is discarded and no `wdone` is issued.

## Configuration
- `PORT_LINK_SKID_EN` defined: each lane is a 2-entry FIFO.
  - `wready` = not full; `rready` = not empty; `rdata` = head entry.
  - A write and a read in the same cycle while FULL are both accepted: pop and push together, count unchanged.
  - `wdone` still pulses once per consumed word, in read order.
- `PORT_LINK_SKID_EN` undefined: single-entry behaviour as in Operation. The writer stalls until the reader consumes the word (strict TIS-100 semantics).

## Structure
- Shared package `tis_pkg`:
  - `tis_word_t` (signed [10:0]).
  - `TIS_MAX = 999`, `TIS_MIN = -999`.
  - Port/operand codes NIL, ACC, ANY, LAST, LEFT, RIGHT, UP, DOWN (1000–1007), replacing per-file defines.
- Sub-module `link_lane`: one direction, holding storage, state, `wdone` pulse and error detect. Instantiated twice.
- `port_link`: wiring only, plus OR of the two lane error flags into `err`.

## Test plan
- Reset then A writes 123 at N → `b_rready=1`, `b_rdata=123` at N+1. B reads at N+1 → `a_wdone` pulse at N+2, `a_wready=1` at N+2.
- A writes 5 while the lane is FULL with 7 → `b_rdata` stays 7, `err=1` and stays 1.
- Both directions in the same cycle: A writes −999, B writes 999 → `b_rdata=−999`, `a_rdata=999`, no `err`.
- `rst_n` asserted while A→B is FULL → `b_rready=0` and `a_wready=1` immediately; no `wdone` after release.
- A writes 1000 → stored, `err=1`.
- With `PORT_LINK_SKID_EN`: A writes 1, 2 back-to-back → `a_wready=0` after the second; a simultaneous read+write of 3 is both accepted; reads return 1, 2, 3 with three `a_wdone` pulses.
